// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and the wrap-around priority search
// used by the eight-way round-robin arbiter.
package arb_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of vec, searching start, start+1, ... and wrapping 7->0.
  // Returns start when vec is zero; callers only use the result when vec!=0.
  function automatic logic [IDX_W-1:0] first_set_from(
    input logic [NREQ-1:0]  vec,
    input logic [IDX_W-1:0] start
  );
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + IDX_W'(k);
      if (!found && vec[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3-bit index to 8-bit one-hot decoder.
module onehot_dec3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);

  // Exactly one bit set, selected by idx.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold time.
// IDLE arbitrates from the priority pointer; GRANT holds until done, the
// grantee drops its request, or HOLD_MAX cycles elapse (forced release with
// a one-cycle timeout pulse). Every release costs one dead IDLE cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             vld_q,   vld_d;
  logic             tout_q,  tout_d;
  logic [NREQ-1:0]  gnt_q,   gnt_d;
  logic [NREQ-1:0]  dec;

  // Decode the next-state winner; the result is registered into gnt so that
  // gnt and gnt_idx always change on the same edge.
  onehot_dec3to8 u_dec (
    .idx    (idx_d),
    .onehot (dec)
  );

  // Next-state logic: arbitration in IDLE, prioritized release in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = first_set_from(req, ptr_q);
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // done wins over a dropped request, both win over the hold limit,
        // so a done in the last allowed cycle never raises timeout.
        if (done || !req[idx_q]) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
        end else if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
    gnt_d = vld_d ? dec : '0;
  end

  // State and output registers; reset also clears any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      tout_q  <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      tout_q  <= tout_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = tout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter8;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_tout  = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of the arbitration rules, using the inputs seen at the edge.
  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_tout = 1'b0;
    end else if (!m_busy) begin
      m_tout = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % 8;
          m_held  = 1;
          break;
        end
      end
    end else if (done || !req[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 8;
      m_tout = 1'b0;
    end else if (m_held == HM) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 8;
      m_tout = 1'b1;
    end else begin
      m_held++;
      m_tout = 1'b0;
    end
  endtask

  task automatic cyc(input bit r, input logic [7:0] rq, input bit d);
    logic [31:0] exp_gnt;
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = m_busy ? (32'h1 << m_owner) : 32'h0;
    chk("gnt",       32'(gnt),       exp_gnt);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    chk("timeout",   32'(timeout),   32'(m_tout));
    chk("onehot",    32'($countones(gnt) <= 1), 32'h1);
    if (m_busy) chk("gnt_idx", 32'(gnt_idx), 32'(m_owner));
  endtask

  initial begin
    logic [7:0] rq;
    int         hold;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // reset with everyone requesting: no grant while rst is high
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("reset_gnt", 32'(gnt), 32'h0);
    cyc(1'b0, 8'hFF, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h01);

    // rotation with done one cycle after each grant
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 8'hFF, 1'b1);
      cyc(1'b0, 8'hFF, 1'b0);
    end
    cyc(1'b0, 8'hFF, 1'b1);

    // skip and wrap: grant 5, then 0x05 goes to 0 then 2
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h20, 1'b0);
    cyc(1'b0, 8'h20, 1'b1);
    cyc(1'b0, 8'h05, 1'b0);
    chk("wrap_gnt0", 32'(gnt), 32'h01);
    cyc(1'b0, 8'h05, 1'b1);
    cyc(1'b0, 8'h05, 1'b0);
    chk("wrap_gnt2", 32'(gnt), 32'h04);
    cyc(1'b0, 8'h05, 1'b1);

    // timeout: requester 3 held for HOLD_MAX cycles, then 4 follows
    cyc(1'b0, 8'h18, 1'b0);
    for (int i = 1; i < HM; i++) cyc(1'b0, 8'h18, 1'b0);
    chk("hold_gnt3", 32'(gnt), 32'h08);
    cyc(1'b0, 8'h18, 1'b0);
    chk("timeout_pulse", 32'(timeout), 32'h1);
    chk("timeout_gnt", 32'(gnt), 32'h0);
    cyc(1'b0, 8'h18, 1'b0);
    chk("after_to_gnt4", 32'(gnt), 32'h10);

    // done in the last allowed cycle: plain release, no pulse
    for (int i = 1; i < HM; i++) cyc(1'b0, 8'h18, 1'b0);
    cyc(1'b0, 8'h18, 1'b1);
    chk("done_vs_to", 32'(timeout), 32'h0);

    // abandon: requester 2 drops, pointer moves to 3
    cyc(1'b0, 8'h04, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("abandon_gnt", 32'(gnt), 32'h0);
    cyc(1'b0, 8'h0C, 1'b0);
    chk("abandon_ptr", 32'(gnt), 32'h08);
    cyc(1'b0, 8'h0C, 1'b1);

    // reset mid-grant: drop grant, restart arbitration at 0
    cyc(1'b0, 8'h80, 1'b0);
    cyc(1'b1, 8'h80, 1'b0);
    chk("mid_rst_to", 32'(timeout), 32'h0);
    cyc(1'b0, 8'hFF, 1'b0);
    chk("mid_rst_gnt", 32'(gnt), 32'h01);

    // random traffic, requests held for random stretches
    rq   = 8'h00;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        rq   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      cyc(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
